// File: rtl/move_merge_if.sv
// rtl/move_merge_if.sv - player-in / board-out handshake bundle for move_merge
interface move_merge_if #(
  parameter int WIDTH = 4
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  // slave: the arbiter's view; master: the players plus board side driving it
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/move_merge.sv
// rtl/move_merge.sv - two-player turn arbiter merging moves onto one registered stream
module move_merge #(
  parameter int WIDTH     = 4,
  parameter int MAX_MOVES = 9,
  parameter int STRICT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  move_merge_if.slave bus,
  output logic        turn,
  output logic [3:0]  move_cnt,
  output logic        full,
  output logic        wrong_turn
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_MOVES);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             turn_q, turn_d;
  logic [3:0]       move_cnt_q, move_cnt_d;
  logic             full_q, full_d;
  logic             wrong_turn_q, wrong_turn_d;

  logic can_load, gate, in0_ready, in1_ready, acc0, acc1;

  always_comb begin
    can_load  = ~out_valid_q | bus.out_ready;
    gate      = can_load & ~full_q & ~new_game & ~rst;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (STRICT != 0) begin
      in0_ready = gate & ~turn_q;
      in1_ready = gate & turn_q;
    end else begin
      // turn only breaks ties; a lone requester is served regardless of turn
      in0_ready = gate & (~turn_q | ~bus.in1_valid);
      in1_ready = gate & (turn_q | ~bus.in0_valid);
    end
    acc0 = bus.in0_valid & in0_ready;
    acc1 = bus.in1_valid & in1_ready;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    turn_d       = turn_q;
    move_cnt_d   = move_cnt_q;
    full_d       = full_q;
    wrong_turn_d = 1'b0;

    if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (acc0 | acc1) begin
      out_valid_d = 1'b1;
      out_data_d  = acc1 ? bus.in1_data : bus.in0_data;
      out_src_d   = acc1;
      turn_d      = ~acc1;
      move_cnt_d  = move_cnt_q + 4'd1;
      full_d      = (move_cnt_q + 4'd1) == MAX_CNT;
    end
    if (STRICT != 0) begin
      wrong_turn_d = turn_q ? bus.in0_valid : bus.in1_valid;
    end
    // new_game discards any pending move but keeps the last payload bits
    if (new_game) begin
      out_valid_d  = 1'b0;
      turn_d       = 1'b0;
      move_cnt_d   = 4'd0;
      full_d       = 1'b0;
      wrong_turn_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      turn_q       <= 1'b0;
      move_cnt_q   <= 4'd0;
      full_q       <= 1'b0;
      wrong_turn_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      turn_q       <= turn_d;
      move_cnt_q   <= move_cnt_d;
      full_q       <= full_d;
      wrong_turn_q <= wrong_turn_d;
    end
  end

  assign bus.in0_ready = in0_ready;
  assign bus.in1_ready = in1_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign turn          = turn_q;
  assign move_cnt      = move_cnt_q;
  assign full          = full_q;
  assign wrong_turn    = wrong_turn_q;

endmodule
